// File: rtl/hit_logger_pkg.sv
// Shared constants and helpers for the hit logger and its upstream colour word detector.
package hit_logger_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_CNT_W = 8;

  localparam logic [7:0] CHAR_C = 8'h43;
  localparam logic [7:0] CHAR_O = 8'h4F;
  localparam logic [7:0] CHAR_L = 8'h4C;
  localparam logic [7:0] CHAR_U = 8'h55;
  localparam logic [7:0] CHAR_R = 8'h52;

  typedef enum logic [1:0] {
    FIFO_IDLE,
    FIFO_PUSH,
    FIFO_POP,
    FIFO_BOTH
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return FIFO_PUSH;
      2'b01:   return FIFO_POP;
      2'b11:   return FIFO_BOTH;
      default: return FIFO_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hit_logger_if.sv
// Hit/read/clear request bundle and timestamp/status response of the hit logger.
interface hit_logger_if
  import hit_logger_pkg::*;
#(
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             HIT;
  logic             clr;
  logic             rd_en;
  logic [TS_W-1:0]  ts_data;
  logic             ts_valid;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output HIT, clr, rd_en,
    input  ts_data, ts_valid, full, overflow, hit_count
  );

  modport slave (
    input  HIT, clr, rd_en,
    output ts_data, ts_valid, full, overflow, hit_count
  );

endinterface

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on dout.
module hit_fifo
  import hit_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_TS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  fifo_op_e      op;

  // A pop frees the slot at the same edge, so a full FIFO still accepts push+pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign op      = fifo_op(do_push, do_pop);

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (op)
        FIFO_PUSH: count <= count + 1'b1;
        FIFO_POP:  count <= count - 1'b1;
        default:   count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hit_logger.sv
// Timestamps each HIT pulse from a free-running timer into a small FIFO and keeps
// a saturating hit counter plus a sticky overflow flag for dropped timestamps.
module hit_logger
  import hit_logger_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TS_W  = DEF_TS_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic         clk,
  input logic         rst,
  hit_logger_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(DEPTH);

  logic [TS_W-1:0]  timer;
  logic [TS_W-1:0]  head;
  logic [CNT_W-1:0] hit_count;
  logic [CW-1:0]    occupancy;
  logic             overflow;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  hit_fifo #(
    .DEPTH(DEPTH),
    .W    (TS_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr),
    .push (bus.HIT),
    .pop  (bus.rd_en),
    .din  (timer),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(occupancy)
  );

  // A hit is only lost when the FIFO is full and no pop makes room at the same edge.
  assign drop = bus.HIT && !bus.rd_en && (occupancy == DEPTH_COUNT);

  // The timer is deliberately immune to clr so timestamps stay monotonic across soft clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      hit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (bus.HIT && (hit_count != '1)) begin
        hit_count <= hit_count + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.ts_data   = head;
  assign bus.ts_valid  = !fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.overflow  = overflow;
  assign bus.hit_count = hit_count;

endmodule
